// File: rtl/ins_commit_if.sv
// ins_commit_if: bundle of every handshake/bus signal of the commit stage.
//   ex_*   : execute-stage result and valid/ready handshake
//   mem_*  : data-memory store request/acknowledge
//   rf_*   : register-file write port
//   pc_*   : program-counter write port
//   commit_done / fault / ret_count : status
// Modports: slave = the commit stage itself, master = its environment
// (execute stage, data memory, register file, PC).
interface ins_commit_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_ready;
    logic            reg_w_op;
    logic [4:0]      reg_w_reg_idx;
    logic [XLEN-1:0] reg_w_reg_val;
    logic            mem_w_op;
    logic [XLEN-1:0] mem_w_mem_addr;
    logic [XLEN-1:0] mem_w_mem_val;
    logic            reg_pc_w_op;
    logic [XLEN-1:0] reg_pc_w_val;
    logic [XLEN-1:0] reg_pc_val;

    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_ack;

    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            pc_we;
    logic [XLEN-1:0] pc_wval;
    logic            commit_done;
    logic            fault;
    logic [31:0]     ret_count;

    modport slave (
        input  ex_valid, reg_w_op, reg_w_reg_idx, reg_w_reg_val,
               mem_w_op, mem_w_mem_addr, mem_w_mem_val,
               reg_pc_w_op, reg_pc_w_val, reg_pc_val, mem_ack,
        output ex_ready, mem_req, mem_addr, mem_data,
               rf_we, rf_waddr, rf_wdata, pc_we, pc_wval,
               commit_done, fault, ret_count
    );

    modport master (
        output ex_valid, reg_w_op, reg_w_reg_idx, reg_w_reg_val,
               mem_w_op, mem_w_mem_addr, mem_w_mem_val,
               reg_pc_w_op, reg_pc_w_val, reg_pc_val, mem_ack,
        input  ex_ready, mem_req, mem_addr, mem_data,
               rf_we, rf_waddr, rf_wdata, pc_we, pc_wval,
               commit_done, fault, ret_count
    );
endinterface

// File: rtl/ins_commit.sv
// ins_commit: commit/writeback stage behind the execute stage.
// Accepts one execute result per ex_valid/ex_ready handshake, performs the
// optional store on the data-memory port (waiting for mem_ack with a
// timeout), then retires the instruction in a single COMMIT cycle that
// strobes the register-file write, the PC update and commit_done.
// Ports:
//   sys_clk  : clock, rising edge
//   sys_rst  : synchronous active-high reset
//   bus      : ins_commit_if.slave carrying execute, memory, register-file,
//              PC and status signals
module ins_commit #(
    parameter int XLEN        = 32,
    parameter int PC_STEP     = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    ins_commit_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEM    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // One extra bit so "count + 1" never wraps before the compare.
    localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            fault_q, fault_d;
    logic [31:0]     ret_q, ret_d;

    logic            cap_rw_q;
    logic [4:0]      cap_idx_q;
    logic [XLEN-1:0] cap_rval_q;
    logic [XLEN-1:0] cap_maddr_q;
    logic [XLEN-1:0] cap_mdata_q;
    logic            cap_pcw_q;
    logic [XLEN-1:0] cap_pcw_val_q;
    logic [XLEN-1:0] cap_pc_q;

    logic            ready;
    logic            xfer;
    logic            in_commit;
    logic [XLEN-1:0] pc_next;

    assign ready     = (state_q == ST_IDLE) && !fault_q;
    assign xfer      = bus.ex_valid && ready;
    assign in_commit = (state_q == ST_COMMIT);
    assign pc_next   = cap_pcw_q ? cap_pcw_val_q : (cap_pc_q + XLEN'(PC_STEP));

    // State, counters and status registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            ret_q   <= ret_d;
        end
    end

    // Capture of the execute result on each accepted transfer.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cap_rw_q      <= 1'b0;
            cap_idx_q     <= '0;
            cap_rval_q    <= '0;
            cap_maddr_q   <= '0;
            cap_mdata_q   <= '0;
            cap_pcw_q     <= 1'b0;
            cap_pcw_val_q <= '0;
            cap_pc_q      <= '0;
        end else if (xfer) begin
            cap_rw_q      <= bus.reg_w_op;
            cap_idx_q     <= bus.reg_w_reg_idx;
            cap_rval_q    <= bus.reg_w_reg_val;
            cap_maddr_q   <= bus.mem_w_mem_addr;
            cap_mdata_q   <= bus.mem_w_mem_val;
            cap_pcw_q     <= bus.reg_pc_w_op;
            cap_pcw_val_q <= bus.reg_pc_w_val;
            cap_pc_q      <= bus.reg_pc_val;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        ret_d   = ret_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    cnt_d   = '0;
                    state_d = bus.mem_w_op ? ST_MEM : ST_COMMIT;
                end
            end
            ST_MEM: begin
                // Ack is checked first, so an ack in the last allowed
                // cycle still succeeds.
                if (bus.mem_ack) begin
                    state_d = ST_COMMIT;
                end else if ({1'b0, cnt_q} + 9'd1 >= TIMEOUT_LIM) begin
                    fault_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_COMMIT: begin
                ret_d   = ret_q + 32'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.ex_ready    = ready;
    assign bus.mem_req     = (state_q == ST_MEM);
    assign bus.mem_addr    = cap_maddr_q;
    assign bus.mem_data    = cap_mdata_q;
    // Writes to x0 are dropped but address/data are still presented.
    assign bus.rf_we       = in_commit && cap_rw_q && (cap_idx_q != 5'd0);
    assign bus.rf_waddr    = cap_idx_q;
    assign bus.rf_wdata    = cap_rval_q;
    assign bus.pc_we       = in_commit;
    assign bus.pc_wval     = in_commit ? pc_next : '0;
    assign bus.commit_done = in_commit;
    assign bus.fault       = fault_q;
    assign bus.ret_count   = ret_q;
endmodule

// File: tb/tb_ins_commit.sv
module tb_ins_commit;
    localparam int XLEN        = 32;
    localparam int PC_STEP     = 4;
    localparam int MEM_TIMEOUT = 16;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    ins_commit_if #(.XLEN(XLEN)) bus ();

    ins_commit #(
        .XLEN(XLEN), .PC_STEP(PC_STEP), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    // Reference model state
    logic [31:0] m_ret   = 32'd0;
    logic        m_fault = 1'b0;

    task automatic scramble_inputs(input logic noise);
        bus.ex_valid       = noise ? 1'($urandom) : 1'b0;
        bus.reg_w_op       = 1'($urandom);
        bus.reg_w_reg_idx  = 5'($urandom);
        bus.reg_w_reg_val  = $urandom;
        bus.mem_w_op       = 1'($urandom);
        bus.mem_w_mem_addr = $urandom;
        bus.mem_w_mem_val  = $urandom;
        bus.reg_pc_w_op    = 1'($urandom);
        bus.reg_pc_w_val   = $urandom;
        bus.reg_pc_val     = $urandom;
    endtask

    // Drives one result and checks every cycle until it retires (or times
    // out). Entered and left on a negedge. ack_dly >= MEM_TIMEOUT means
    // mem_ack is never given.
    task automatic run_txn(input string name, input logic rw, input logic [4:0] idx,
                           input logic [31:0] rv, input logic mw, input logic [31:0] ma,
                           input logic [31:0] md, input logic pw, input logic [31:0] pv,
                           input logic [31:0] pcv, input int ack_dly, input logic noise);
        logic [31:0] exp_pc;
        logic        exp_rfwe;
        logic        acked;
        exp_pc   = pw ? pv : pcv + 32'(PC_STEP);
        exp_rfwe = rw && (idx != 5'd0);

        n_checks++;
        if (bus.ex_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before: got %b want 1", name, bus.ex_ready);
        end
        bus.ex_valid = 1'b1; bus.reg_w_op = rw; bus.reg_w_reg_idx = idx;
        bus.reg_w_reg_val = rv; bus.mem_w_op = mw; bus.mem_w_mem_addr = ma;
        bus.mem_w_mem_val = md; bus.reg_pc_w_op = pw; bus.reg_pc_w_val = pv;
        bus.reg_pc_val = pcv;
        @(negedge sys_clk);
        scramble_inputs(noise);
        n_checks++;
        if (bus.ex_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_busy: got %b want 0", name, bus.ex_ready);
        end

        if (mw) begin
            acked = 1'b0;
            for (int i = 0; i < MEM_TIMEOUT; i++) begin
                n_checks++;
                if ({bus.mem_req, bus.mem_addr, bus.mem_data, bus.rf_we, bus.pc_we, bus.commit_done}
                    !== {1'b1, ma, md, 3'b000}) begin
                    n_fail++;
                    $display("FAIL %s mem_wait[%0d]: got req=%b a=%h d=%h strobes=%b want req=1 a=%h d=%h strobes=000",
                             name, i, bus.mem_req, bus.mem_addr, bus.mem_data,
                             {bus.rf_we, bus.pc_we, bus.commit_done}, ma, md);
                end
                if (i == ack_dly) begin
                    bus.mem_ack = 1'b1;
                    acked = 1'b1;
                end
                @(negedge sys_clk);
                bus.mem_ack = 1'b0;
                scramble_inputs(noise);
                if (acked) break;
            end
            if (!acked) begin
                m_fault = 1'b1;
                bus.ex_valid = 1'b0;
                n_checks++;
                if ({bus.mem_req, bus.fault, bus.ex_ready, bus.commit_done, bus.pc_we, bus.rf_we, bus.ret_count}
                    !== {1'b0, m_fault, 1'b0, 3'b000, m_ret}) begin
                    n_fail++;
                    $display("FAIL %s timeout: got req=%b fault=%b rdy=%b strobes=%b ret=%0d want req=0 fault=1 rdy=0 strobes=000 ret=%0d",
                             name, bus.mem_req, bus.fault, bus.ex_ready,
                             {bus.commit_done, bus.pc_we, bus.rf_we}, bus.ret_count, m_ret);
                end
                $display("txn %s: store a=%h timed out", name, ma);
                return;
            end
        end

        // Commit cycle
        n_checks++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.pc_we, bus.pc_wval, bus.commit_done, bus.mem_req, bus.ex_ready}
            !== {exp_rfwe, idx, rv, 1'b1, exp_pc, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s commit: got we=%b ad=%0d wd=%h pcwe=%b pc=%h cd=%b req=%b rdy=%b want we=%b ad=%0d wd=%h pcwe=1 pc=%h cd=1 req=0 rdy=0",
                     name, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.pc_we, bus.pc_wval,
                     bus.commit_done, bus.mem_req, bus.ex_ready, exp_rfwe, idx, rv, exp_pc);
        end
        bus.ex_valid = 1'b0;
        @(negedge sys_clk);
        m_ret = m_ret + 32'd1;
        n_checks++;
        if ({bus.ret_count, bus.ex_ready, bus.rf_we, bus.pc_we, bus.commit_done}
            !== {m_ret, 1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL %s after_commit: got ret=%0d rdy=%b strobes=%b want ret=%0d rdy=1 strobes=000",
                     name, bus.ret_count, bus.ex_ready, {bus.rf_we, bus.pc_we, bus.commit_done}, m_ret);
        end
        $display("txn %s: rw=%b idx=%0d mw=%b ack=%0d pc=%h -> pc_wval=%h ret=%0d",
                 name, rw, idx, mw, ack_dly, pcv, exp_pc, m_ret);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        bus.mem_ack = 1'b0;
        scramble_inputs(1'b0);
        repeat (2) @(negedge sys_clk);
        m_ret = 32'd0; m_fault = 1'b0;
        n_checks++;
        if ({bus.ex_ready, bus.mem_req, bus.mem_addr, bus.mem_data, bus.rf_we, bus.rf_waddr,
             bus.rf_wdata, bus.pc_we, bus.pc_wval, bus.commit_done, bus.fault, bus.ret_count}
            !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset: got rdy=%b req=%b a=%h d=%h we=%b wa=%0d wd=%h pcwe=%b pc=%h cd=%b f=%b ret=%0d want rdy=1 and all others 0",
                     bus.ex_ready, bus.mem_req, bus.mem_addr, bus.mem_data, bus.rf_we, bus.rf_waddr,
                     bus.rf_wdata, bus.pc_we, bus.pc_wval, bus.commit_done, bus.fault, bus.ret_count);
        end
        sys_rst = 1'b0;
        @(negedge sys_clk);
        $display("txn reset: done");
    endtask

    task automatic test_directed();
        run_txn("alu",    1'b1, 5'd5, 32'h1234, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,    32'h100,      0, 1'b0);
        run_txn("x0",     1'b1, 5'd0, 32'hFFFF, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,    32'h200,      0, 1'b0);
        run_txn("branch", 1'b0, 5'd3, 32'h7,    1'b0, 32'h0, 32'h0, 1'b1, 32'h2000, 32'h300,      0, 1'b0);
        run_txn("wrap",   1'b0, 5'd3, 32'h7,    1'b0, 32'h0, 32'h0, 1'b0, 32'h0,    32'hFFFFFFFC, 0, 1'b0);
        run_txn("store3", 1'b0, 5'd9, 32'h9,    1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0, 32'h400, 2, 1'b1);
        run_txn("ack0",   1'b1, 5'd7, 32'h77,   1'b1, 32'h44, 32'h12345678, 1'b0, 32'h0, 32'h404, 0, 1'b0);
        run_txn("acklast",1'b1, 5'd8, 32'h88,   1'b1, 32'h48, 32'hCAFEF00D, 1'b1, 32'h800, 32'h408,
                MEM_TIMEOUT - 1, 1'b1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic mw;
            int   dly;
            mw  = ($urandom_range(0, 2) == 0);
            dly = $urandom_range(0, MEM_TIMEOUT - 1);
            run_txn($sformatf("rnd%0d", t), 1'($urandom), ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                    $urandom, mw, $urandom, $urandom, 1'($urandom), $urandom, $urandom, dly, 1'b1);
            // Random idle gap; zero keeps results back to back.
            repeat ($urandom_range(0, 2)) @(negedge sys_clk);
        end
    endtask

    task automatic test_timeout();
        run_txn("timeout", 1'b1, 5'd4, 32'h44, 1'b1, 32'h80, 32'h55AA55AA, 1'b0, 32'h0, 32'h500,
                MEM_TIMEOUT, 1'b0);
        // Results offered while faulted must be ignored.
        bus.ex_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            n_checks++;
            if ({bus.ex_ready, bus.fault, bus.commit_done, bus.mem_req, bus.ret_count}
                !== {1'b0, 1'b1, 1'b0, 1'b0, m_ret}) begin
                n_fail++;
                $display("FAIL fault_hold[%0d]: got rdy=%b f=%b cd=%b req=%b ret=%0d want rdy=0 f=1 cd=0 req=0 ret=%0d",
                         i, bus.ex_ready, bus.fault, bus.commit_done, bus.mem_req, bus.ret_count, m_ret);
            end
        end
        bus.ex_valid = 1'b0;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        m_fault = 1'b0; m_ret = 32'd0;
        n_checks++;
        if ({bus.fault, bus.ex_ready, bus.ret_count} !== {m_fault, 1'b1, m_ret}) begin
            n_fail++;
            $display("FAIL fault_clear: got f=%b rdy=%b ret=%0d want f=0 rdy=1 ret=0",
                     bus.fault, bus.ex_ready, bus.ret_count);
        end
        $display("txn fault_clear: reset after timeout");
    endtask

    task automatic test_reset_mid_store();
        run_txn("pre", 1'b1, 5'd1, 32'h11, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h600, 0, 1'b0);
        bus.ex_valid = 1'b1; bus.mem_w_op = 1'b1; bus.mem_w_mem_addr = 32'hC0;
        bus.mem_w_mem_val = 32'h0BADF00D; bus.reg_w_op = 1'b1; bus.reg_w_reg_idx = 5'd2;
        bus.reg_pc_w_op = 1'b0; bus.reg_pc_val = 32'h604;
        @(negedge sys_clk);
        bus.ex_valid = 1'b0;
        repeat (2) @(negedge sys_clk);
        n_checks++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_store_req: got %b want 1", bus.mem_req);
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        bus.mem_ack = 1'b1;   // a late ack must not revive the abandoned store
        sys_rst = 1'b0;
        m_ret = 32'd0;
        n_checks++;
        if ({bus.mem_req, bus.ex_ready, bus.ret_count, bus.commit_done, bus.rf_we, bus.pc_we}
            !== {1'b0, 1'b1, m_ret, 3'b000}) begin
            n_fail++;
            $display("FAIL mid_store_rst: got req=%b rdy=%b ret=%0d strobes=%b want req=0 rdy=1 ret=0 strobes=000",
                     bus.mem_req, bus.ex_ready, bus.ret_count, {bus.commit_done, bus.rf_we, bus.pc_we});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            bus.mem_ack = 1'b0;
            n_checks++;
            if ({bus.commit_done, bus.mem_req, bus.ret_count} !== {1'b0, 1'b0, m_ret}) begin
                n_fail++;
                $display("FAIL mid_store_quiet[%0d]: got cd=%b req=%b ret=%0d want cd=0 req=0 ret=%0d",
                         i, bus.commit_done, bus.mem_req, bus.ret_count, m_ret);
            end
        end
        $display("txn reset_mid_store: store abandoned");
        run_txn("post", 1'b1, 5'd6, 32'h66, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h700, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ins_commit.md
Name: ins_commit

Overview:
- Commit/writeback stage directly downstream of the execute stage.
- Captures one execute result per handshake: register write, memory store and PC write-back.
- Issues the store to the data-memory port and waits for acknowledge, with a timeout.
- Then applies the register-file write and PC update in a single commit cycle and counts retired instructions.

Parameters:
XLEN, 32, datapath width of register values, addresses and PC.
PC_STEP, 4, PC increment applied when execute requests no PC write.
MEM_TIMEOUT, 16, maximum cycles to wait for mem_ack before faulting (legal range 1..255).

Ports:
sys_clk  in  1  clock; all logic on rising edge.
sys_rst  in  1  synchronous active-high reset.
ex_valid  in  1  execute result valid this cycle.
ex_ready  out  1  high when the block can accept a result (state IDLE and no fault).
reg_w_op  in  1  register write requested.
reg_w_reg_idx  in  5  destination register index.
reg_w_reg_val  in  XLEN  destination value.
mem_w_op  in  1  store requested.
mem_w_mem_addr  in  XLEN  store address.
mem_w_mem_val  in  XLEN  store data.
reg_pc_w_op  in  1  PC redirect requested.
reg_pc_w_val  in  XLEN  redirect target.
reg_pc_val  in  XLEN  PC of the instruction being committed.
mem_req  out  1  store request, held until ack or timeout.
mem_addr  out  XLEN  store address.
mem_data  out  XLEN  store data.
mem_ack  in  1  store accepted.
rf_we  out  1  register-file write strobe (one cycle).
rf_waddr  out  5  register-file write index.
rf_wdata  out  XLEN  register-file write data.
pc_we  out  1  PC write strobe (one cycle).
pc_wval  out  XLEN  next PC.
commit_done  out  1  one-cycle pulse per retired instruction.
fault  out  1  sticky store-timeout flag.
ret_count  out  32  retired-instruction counter.

Behaviour:
- Reset: all outputs 0 except ex_ready=1; state IDLE; capture registers cleared; fault=0; ret_count=0. Reset mid-transaction abandons any store immediately: mem_req=0 next cycle, nothing commits.
- States: IDLE, MEM, COMMIT.
- Transfer rule: a transfer occurs when ex_valid && ex_ready on a rising edge. ex_valid while ex_ready=0 is ignored; it is not queued.
- On transfer, capture all ex_* fields and reg_pc_val.
  - If mem_w_op=1: go to MEM, mem_req=1 from the next cycle with mem_addr/mem_data from the capture, wait counter=0.
  - Else: go to COMMIT.
- MEM:
  - mem_ack=1 in a cycle with mem_req=1 → mem_req=0 next cycle, go to COMMIT.
  - Otherwise the counter increments each cycle.
  - Counter reaching MEM_TIMEOUT without ack → mem_req=0, fault=1 (sticky until reset), go to IDLE. No register write, PC write, commit_done or count increment.
  - ack arriving in the same cycle the counter reaches MEM_TIMEOUT counts as success.
  - mem_addr/mem_data stay stable while mem_req=1.
- COMMIT, for exactly one cycle:
  - pc_we=1.
  - pc_wval = captured reg_pc_w_val if reg_pc_w_op, else captured pc + PC_STEP, mod 2^XLEN (wraps).
  - rf_we=1 only if reg_w_op=1 and reg_w_reg_idx≠0; a write to x0 is suppressed and rf_waddr/rf_wdata are still driven.
  - commit_done=1; ret_count += 1 (wraps 0xFFFFFFFF→0).
  - Next state IDLE.
- Latency:
  - Non-store: transfer at edge N → commit strobes high in cycle N+1 → ex_ready high again in N+2.
  - Store acked k cycles after mem_req rises (k≥0): commit at N+k+2.
- Throughput: at most one instruction per 2 cycles.
- Fault: while fault=1, ex_ready=0 permanently until sys_rst.
- rf_we/pc_we/commit_done are 0 in every state other than COMMIT.

Test Plan:
- ALU result: reg_w_op=1, idx=5, val=0x1234, pc=0x100, no redirect → one cycle later rf_we=1, rf_waddr=5, rf_wdata=0x1234, pc_we=1, pc_wval=0x104, ret_count=1; ex_ready low exactly one cycle.
- x0 write: reg_w_op=1, idx=0, val=0xFFFF → rf_we stays 0; pc_we=1; commit_done=1.
- Branch and wrap:
  - reg_pc_w_op=1, val=0x2000 → pc_wval=0x2000.
  - pc=0xFFFFFFFC, no redirect → pc_wval=0x00000000.
- Store with 3-cycle ack delay: addr=0x40, data=0xDEADBEEF → mem_req held 3 cycles with stable addr/data; commit the cycle after ack; rf_we=0.
- Timeout: store with mem_ack never asserted, MEM_TIMEOUT=16 → mem_req drops after 16 cycles, fault=1, no commit_done, ex_ready stays 0; sys_rst then clears fault and sets ex_ready=1.
- Reset mid-store: assert sys_rst while mem_req=1 → mem_req=0 and state IDLE next cycle; ret_count=0; no commit pulse.
